// File: rtl/ctr_seq.sv
// ctr_seq: parametrised multi-cycle control sequencer.
//
// Steps a one-hot enable through NSTAGES pipeline-phase enables. It supports
// stall hold, per-instruction stage skipping, halt/resume, single-step mode
// and a retired-instruction counter.
//
// Ports:
//   I_clk         clock; all state changes on the rising edge
//   I_reset       synchronous, active-high reset
//   I_stall       hold the current stage
//   I_skip        per-stage skip mask (bit 0 ignored), sampled every advance
//   I_halt        enter HALTED at the next completion (or from PAUSE)
//   I_run         leave HALTED
//   I_step_mode   pause after every instruction
//   I_step        leave PAUSE and run one instruction
//   O_en          one-hot stage enable, zero in PAUSE/HALTED
//   O_stage       binary index of the active stage, 0 when idle
//   O_active      high in RUN
//   O_halted      high in HALTED
//   O_instr_done  one-cycle pulse after each completed instruction
//   O_instr_cnt   completed-instruction count, wraps
module ctr_seq #(
  parameter int NSTAGES = 6,
  parameter int CNT_W   = 16,
  localparam int SW     = (NSTAGES > 1) ? $clog2(NSTAGES) : 1
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic               I_stall,
  input  logic [NSTAGES-1:0] I_skip,
  input  logic               I_halt,
  input  logic               I_run,
  input  logic               I_step_mode,
  input  logic               I_step,
  output logic [NSTAGES-1:0] O_en,
  output logic [SW-1:0]      O_stage,
  output logic               O_active,
  output logic               O_halted,
  output logic               O_instr_done,
  output logic [CNT_W-1:0]   O_instr_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSE  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        stage_q, stage_d;
  logic [NSTAGES-1:0]   en_q, en_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;

  logic                 nxt_found;
  logic [SW-1:0]        nxt_idx;

  // Lowest non-skipped stage above the current one. Scanning downward lets
  // the last hit win, which is the lowest index. Stage 0 can never satisfy
  // j > stage_q, so its skip bit has no effect.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int j = NSTAGES - 1; j >= 0; j--) begin
      if (j > int'(stage_q) && !I_skip[j]) begin
        nxt_found = 1'b1;
        nxt_idx   = SW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!I_stall) begin
          if (nxt_found) begin
            stage_d = nxt_idx;
          end else begin
            // Completion edge: halt wins over step mode.
            cnt_d   = cnt_q + CNT_W'(1);
            done_d  = 1'b1;
            stage_d = '0;
            if (I_halt)
              state_d = ST_HALTED;
            else if (I_step_mode)
              state_d = ST_PAUSE;
          end
        end
      end
      ST_PAUSE: begin
        stage_d = '0;
        if (I_halt)
          state_d = ST_HALTED;
        else if (I_step)
          state_d = ST_RUN;
      end
      ST_HALTED: begin
        stage_d = '0;
        if (I_run)
          state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        stage_d = '0;
      end
    endcase
    // Enable is registered alongside the state so outputs carry no input path.
    en_d = (state_d == ST_RUN) ? (NSTAGES'(1) << stage_d) : '0;
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q <= ST_RUN;
      stage_q <= '0;
      en_q    <= NSTAGES'(1);
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign O_en         = en_q;
  assign O_stage      = stage_q;
  assign O_active     = (state_q == ST_RUN);
  assign O_halted     = (state_q == ST_HALTED);
  assign O_instr_done = done_q;
  assign O_instr_cnt  = cnt_q;

endmodule

// File: tb/tb_ctr_seq.sv
// Testbench for ctr_seq (NSTAGES=6, CNT_W=4): directed scenarios followed by
// randomized stimulus, all checked against a behavioural model every cycle.
module tb_ctr_seq;
  localparam int NS = 6;
  localparam int CW = 4;
  localparam int SW = $clog2(NS);

  logic          clk = 1'b0;
  logic          reset, stall, halt, run, step_mode, step;
  logic [NS-1:0] skip;
  logic [NS-1:0] o_en;
  logic [SW-1:0] o_stage;
  logic          o_active, o_halted, o_done;
  logic [CW-1:0] o_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0=RUN, 1=PAUSE, 2=HALTED.
  int ref_mode, ref_stage, ref_cnt;
  bit ref_done;

  always #5 clk = ~clk;

  ctr_seq #(.NSTAGES(NS), .CNT_W(CW)) dut (
    .I_clk(clk), .I_reset(reset), .I_stall(stall), .I_skip(skip),
    .I_halt(halt), .I_run(run), .I_step_mode(step_mode), .I_step(step),
    .O_en(o_en), .O_stage(o_stage), .O_active(o_active),
    .O_halted(o_halted), .O_instr_done(o_done), .O_instr_cnt(o_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs in effect.
  task automatic model_step();
    int nxt;
    if (reset) begin
      ref_mode = 0; ref_stage = 0; ref_cnt = 0; ref_done = 0;
      return;
    end
    ref_done = 0;
    if (ref_mode == 0) begin
      if (!stall) begin
        nxt = -1;
        for (int j = ref_stage + 1; j < NS; j++)
          if (nxt < 0 && !skip[j]) nxt = j;
        if (nxt >= 0) ref_stage = nxt;
        else begin
          ref_cnt   = (ref_cnt + 1) % (1 << CW);
          ref_done  = 1;
          ref_stage = 0;
          if (halt) ref_mode = 2;
          else if (step_mode) ref_mode = 1;
        end
      end
    end else if (ref_mode == 1) begin
      if (halt) ref_mode = 2;
      else if (step) ref_mode = 0;
    end else begin
      if (run) ref_mode = 0;
    end
  endtask

  task automatic check_all();
    chk("en",     32'(o_en),     (ref_mode == 0) ? (32'd1 << ref_stage) : 32'd0);
    chk("stage",  32'(o_stage),  (ref_mode == 0) ? 32'(ref_stage) : 32'd0);
    chk("active", 32'(o_active), 32'(ref_mode == 0));
    chk("halted", 32'(o_halted), 32'(ref_mode == 2));
    chk("done",   32'(o_done),   32'(ref_done));
    chk("cnt",    32'(o_cnt),    32'(ref_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until(input int mode, input int stage);
    int budget = 40;
    while (!(ref_mode == mode && (mode != 0 || ref_stage == stage)) && budget > 0) begin
      tick();
      budget--;
    end
    n_cmp++;
    if (budget == 0) begin
      n_bad++;
      $error("FAIL wait: observed timeout expected mode %0d stage %0d", mode, stage);
    end
  endtask

  initial begin
    int base;
    reset = 1; stall = 0; halt = 0; run = 0; step_mode = 0; step = 0; skip = '0;
    ref_mode = 0; ref_stage = 0; ref_cnt = 0; ref_done = 0;
    @(negedge clk);
    tick(); tick();
    chk("rst_en", 32'(o_en), 32'd1);
    chk("rst_cnt", 32'(o_cnt), 32'd0);
    reset = 0;

    // Plain sequence: one-hot walk, done pulses in cycles 6 and 12.
    for (int i = 0; i < 14; i++) begin
      if (i > 0) tick();
      chk("seq_en", 32'(o_en), 32'd1 << (i % NS));
      chk("seq_done", 32'(o_done), 32'(i == 6 || i == 12));
      if (i == 12) chk("seq_cnt", 32'(o_cnt), 32'd2);
    end

    // Skip stages 2 and 5: order 0,1,3,4.
    run_until(0, 0);
    skip = 6'b100100;
    for (int i = 0; i < 9; i++) begin
      chk("skip_stage", 32'(o_stage), (i % 4 < 2) ? 32'(i % 4) : 32'(i % 4 + 1));
      tick();
    end
    skip = '0;

    // Stall 3 cycles at stage 2.
    run_until(0, 2);
    stall = 1;
    tick(); tick(); tick();
    chk("stall_hold", 32'(o_en), 32'd4);
    stall = 0;
    tick();
    chk("stall_rel", 32'(o_en), 32'd8);

    // Halt at stage 3: stages 4,5 finish, then HALTED.
    run_until(0, 3);
    halt = 1;
    tick(); tick(); tick();
    chk("halt_h", 32'(o_halted), 32'd1);
    chk("halt_en", 32'(o_en), 32'd0);
    chk("halt_done", 32'(o_done), 32'd1);
    halt = 0;
    tick();
    chk("halt_done2", 32'(o_done), 32'd0);
    run = 1; tick(); run = 0;
    chk("run_en", 32'(o_en), 32'd1);
    chk("run_h", 32'(o_halted), 32'd0);

    // Single-step mode: three step pulses give three completions.
    step_mode = 1;
    run_until(1, 0);
    base = ref_cnt;
    for (int k = 0; k < 3; k++) begin
      step = 1; tick(); step = 0;
      chk("step_en", 32'(o_en), 32'd1);
      run_until(1, 0);
      chk("step_idle", 32'(o_en), 32'd0);
    end
    chk("step_cnt", 32'(o_cnt), 32'((base + 3) % 16));
    step_mode = 0;
    step = 1; tick(); step = 0;

    // All stages skipped: completion every cycle, counter wraps through 0.
    skip = '1;
    for (int i = 0; i < 20; i++) tick();
    skip = '0;

    // Reset mid-instruction at stage 4.
    run_until(0, 4);
    reset = 1; tick(); reset = 0;
    chk("mid_rst_en", 32'(o_en), 32'd1);
    chk("mid_rst_cnt", 32'(o_cnt), 32'd0);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      stall     = ($urandom_range(0, 7) == 0);
      skip      = NS'($urandom) & NS'($urandom);
      halt      = ($urandom_range(0, 15) == 0);
      run       = ($urandom_range(0, 3) == 0);
      step_mode = ($urandom_range(0, 3) == 0);
      step      = ($urandom_range(0, 2) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ctr_seq.md
# ctr_seq

Parametrised multi-cycle control sequencer, the successor to the fixed six-stage one-hot controller. It steps a one-hot enable vector through `NSTAGES` pipeline-phase enables (fetch, decode, register read, ALU, register write, memory, ...). Additions over the fixed controller:
- stall hold;
- per-instruction stage skipping;
- halt/resume;
- single-step mode;
- retired-instruction counter.

It sits between the top-level CPU wrapper and the datapath stage enables.

## Interface
Parameters:
- `NSTAGES`, default 6: number of stages/enables; legal range 2..32.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `I_clk`  in  1  clock; all state changes on the rising edge.
- `I_reset`  in  1  synchronous, active-high reset.
- `I_stall`  in  1  hold the current stage; no advance.
- `I_skip`  in  NSTAGES  per-stage skip mask for the current instruction; bit 0 is ignored.
- `I_halt`  in  1  enter HALTED at the next instruction completion.
- `I_run`  in  1  leave HALTED.
- `I_step_mode`  in  1  single-step mode enable.
- `I_step`  in  1  leave PAUSE and run one instruction.
- `O_en`  out  NSTAGES  one-hot stage enable; all zero in PAUSE/HALTED.
- `O_stage`  out  clog2(NSTAGES)  binary index of the active stage; 0 when idle.
- `O_active`  out  1  high in RUN.
- `O_halted`  out  1  high in HALTED.
- `O_instr_done`  out  1  one-cycle pulse per completed instruction.
- `O_instr_cnt`  out  CNT_W  completed-instruction count; wraps modulo 2^CNT_W.

## Operation
- States: RUN (carries the stage index k), PAUSE, HALTED.
- Reset (highest priority, any state, any cycle):
  - state → RUN, stage 0;
  - `O_en` = 1 (bit 0 only), `O_stage` = 0, `O_active` = 1;
  - `O_halted` = 0, `O_instr_done` = 0, `O_instr_cnt` = 0.
- RUN, `I_stall` = 1: stage held. Stall has priority over skip, halt and step.
- RUN, `I_stall` = 0, stage k: next stage is the lowest j with k < j < NSTAGES and `I_skip[j]` = 0.
  - `I_skip` is sampled every advancing cycle, not latched per instruction.
- If no such j exists, this edge is the completion edge:
  - `O_instr_cnt` increments;
  - `O_instr_done` is registered high for the following cycle only;
  - if `I_halt` = 1 → HALTED;
  - else if `I_step_mode` = 1 → PAUSE;
  - else → RUN stage 0.
  - `I_halt` has priority over `I_step_mode`.
- Stage 0 is never skipped. With all bits of `I_skip` set, each instruction is 1 cycle long and completes every cycle.
- PAUSE: `O_en` = 0. `I_step` = 1 → RUN stage 0 next edge. `I_halt` = 1 in PAUSE → HALTED, with priority over `I_step`.
- HALTED: `O_en` = 0, `O_halted` = 1. `I_run` = 1 → RUN stage 0 next edge. `I_step` is ignored.
- `I_halt`/`I_step_mode` are sampled only at the completion edge (and in PAUSE). They do not abort an instruction mid-flight.
- Counter: `CNT_W`-bit unsigned, +1 per completion, all-ones → 0 wrap. No other source modifies it.
- Invariant: `O_en` has at most one bit set. It is zero-hot exactly in PAUSE/HALTED.

## Timing
- All outputs are registered; no combinational input→output paths.
- No-skip, no-stall instruction: `NSTAGES` cycles. Back-to-back instructions have no idle cycle.
- Skip: each skipped stage removes exactly one cycle.
- `O_instr_done` is high in the first cycle after completion: coincident with stage 0 of the next instruction, or the first PAUSE/HALTED cycle.
- HALTED/PAUSE exit: first stage-0 cycle is the cycle after the edge sampling `I_run`/`I_step` = 1.
- Reset asserted mid-instruction: the next cycle is stage 0, count 0. The partial instruction is not counted.

## Test plan
- NSTAGES=6, no stall/skip/halt, 14 cycles after reset:
  - `O_en` sequence 1,2,4,8,16,32,1,…;
  - `O_instr_done` pulses in cycles 6 and 12;
  - `O_instr_cnt` = 2 by cycle 12.
- `I_skip`=6'b100100 held: stage order 0,1,3,4, then wrap. 4-cycle instructions; `O_stage` sequence 0,1,3,4,0.
- `I_stall` high for 3 cycles at stage 2: `O_en` = 4 for 4 cycles total, then 8. Count unaffected until completion.
- `I_halt`=1 asserted at stage 3:
  - stages 4,5 complete;
  - `O_en` = 0, `O_halted` = 1, `O_instr_done` = 1 for one cycle;
  - `I_run` pulse → stage 0 next cycle, `O_halted` = 0.
- `I_step_mode`=1: after each instruction `O_en` = 0 until an `I_step` pulse. Three `I_step` pulses → `O_instr_cnt` = 3.
- CNT_W=4: 16 completions → counter wraps 15→0. Reset asserted at stage 4 → stage 0 and count 0 on the next cycle.
